// File: rtl/clock_drp_reconfig.sv
// clock_drp_reconfig: MMCM DRP read-modify-write reconfiguration with reset/lock sequencing
// Ports: clk_in (DCLK) and reset (async); start/mode_sel request; busy/done/error/err_code status;
//   mmcm_rst/mmcm_locked/locked_out drive and qualify the MMCM; drp_* is the DRP master interface.
module clock_drp_reconfig #(
  parameter int NUM_MODES = 2,
  parameter int NUM_REGS = 4,
  parameter logic [NUM_MODES*NUM_REGS*39-1:0] MODE_TABLE = '0,
  parameter int DRP_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int RST_HOLD = 8,
  localparam int MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic          clk_in,
  input  logic          reset,
  input  logic          start,
  input  logic [MW-1:0] mode_sel,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [1:0]    err_code,
  output logic          mmcm_rst,
  input  logic          mmcm_locked,
  output logic          locked_out,
  output logic [6:0]    drp_daddr,
  output logic [15:0]   drp_di,
  output logic          drp_den,
  output logic          drp_dwe,
  input  logic [15:0]   drp_do,
  input  logic          drp_drdy
);
  localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int TA = (DRP_TIMEOUT > RST_HOLD) ? DRP_TIMEOUT : RST_HOLD;
  localparam int TMAX = (LOCK_TIMEOUT > TA) ? LOCK_TIMEOUT : TA;
  localparam int CW = $clog2(TMAX + 1);
  typedef enum logic [3:0] {IDLE, RST, RD, RD_WAIT, WR, WR_WAIT, HOLD, LOCK_WAIT, DONE} state_t;
  state_t state;
  logic [MW-1:0] mode;
  logic [RW-1:0] r;
  logic [RW-1:0] sel_r;
  logic [CW-1:0] cnt;
  logic [38:0] tbl [NUM_MODES][NUM_REGS];
  logic [38:0] ent;
  logic lock_m, lock_s, last, legal;
  for (genvar m = 0; m < NUM_MODES; m++) begin : g_m
    for (genvar q = 0; q < NUM_REGS; q++) begin : g_q
      assign tbl[m][q] = MODE_TABLE[39*(m*NUM_REGS+q) +: 39];
    end
  end
  // Registered DRP outputs are loaded one edge early, so leaving WR_WAIT looks up the next entry
  always_comb begin
    last = (r == RW'(NUM_REGS - 1));
    legal = {1'b0, mode_sel} < (MW+1)'(NUM_MODES);
    sel_r = (state == WR_WAIT && !last) ? r + 1'b1 : r;
    ent = tbl[mode][sel_r];
  end
  always_ff @(posedge clk_in or posedge reset)
    if (reset) begin
      state <= IDLE;
      mode <= '0;
      r <= '0;
      cnt <= '0;
      lock_m <= 1'b0;
      lock_s <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      err_code <= 2'b00;
      mmcm_rst <= 1'b0;
      locked_out <= 1'b0;
      drp_den <= 1'b0;
      drp_dwe <= 1'b0;
      drp_daddr <= '0;
      drp_di <= '0;
    end else begin
      lock_m <= mmcm_locked;
      lock_s <= lock_m;
      locked_out <= lock_s & ~busy;
      done <= 1'b0;
      drp_den <= 1'b0;
      drp_dwe <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (legal) begin
            mode <= mode_sel;
            r <= '0;
            error <= 1'b0;
            err_code <= 2'b00;
            busy <= 1'b1;
            mmcm_rst <= 1'b1;
            locked_out <= 1'b0;
            state <= RST;
          end else begin
            error <= 1'b1;
            err_code <= 2'b11;
          end
        end
        RST: begin
          drp_den <= 1'b1;
          drp_daddr <= ent[38:32];
          state <= RD;
        end
        RD: begin
          cnt <= '0;
          state <= RD_WAIT;
        end
        RD_WAIT: if (drp_drdy) begin
          drp_den <= 1'b1;
          drp_dwe <= 1'b1;
          drp_di <= (drp_do & ent[31:16]) | ent[15:0];
          state <= WR;
        end else if (cnt == CW'(DRP_TIMEOUT - 1)) begin
          error <= 1'b1;
          err_code <= 2'b01;
          mmcm_rst <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end else cnt <= cnt + 1'b1;
        WR: begin
          cnt <= '0;
          state <= WR_WAIT;
        end
        WR_WAIT: if (drp_drdy) begin
          cnt <= '0;
          if (last) state <= HOLD;
          else begin
            r <= r + 1'b1;
            drp_den <= 1'b1;
            drp_daddr <= ent[38:32];
            state <= RD;
          end
        end else if (cnt == CW'(DRP_TIMEOUT - 1)) begin
          error <= 1'b1;
          err_code <= 2'b01;
          mmcm_rst <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end else cnt <= cnt + 1'b1;
        HOLD: if (cnt == CW'(RST_HOLD - 1)) begin
          cnt <= '0;
          mmcm_rst <= 1'b0;
          state <= LOCK_WAIT;
        end else cnt <= cnt + 1'b1;
        LOCK_WAIT: if (lock_s) state <= DONE;
        else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
          error <= 1'b1;
          err_code <= 2'b10;
          busy <= 1'b0;
          state <= IDLE;
        end else cnt <= cnt + 1'b1;
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_clock_drp_reconfig.sv
// tb_clock_drp_reconfig: randomized self-checking bench with DRP register-file and MMCM lock models
module tb_clock_drp_reconfig;
  localparam int NM = 3, NR = 4, D = 3, LOCK_DLY = 100, LT = 400, HOLD = 8, DT = 64;
  localparam logic [NM*NR*39-1:0] TBL = {
    {7'h7F, 16'hAAAA, 16'h5555}, {7'h16, 16'h0000, 16'h0000}, {7'h4F, 16'hFF00, 16'h00C3}, {7'h4E, 16'h1234, 16'h0001},
    {7'h28, 16'h0000, 16'hFFFF}, {7'h0B, 16'h0F0F, 16'h3030}, {7'h0A, 16'h8000, 16'h0041}, {7'h08, 16'h00FF, 16'h5600},
    {7'h15, 16'hFFFF, 16'h0000}, {7'h14, 16'hF0F0, 16'h0A0A}, {7'h09, 16'h0000, 16'h1234}, {7'h08, 16'hFF00, 16'h0012}};
  logic clk = 0, reset, start;
  logic [1:0] mode_sel;
  logic busy, done, error, mmcm_rst, locked_out, drp_den, drp_dwe;
  logic [1:0] err_code;
  logic [6:0] drp_daddr;
  logic [15:0] drp_di;
  logic mmcm_locked = 0, drp_drdy = 0;
  logic [15:0] drp_do = 0;
  logic [NM*NR*39-1:0] tbl_v = TBL;
  logic [15:0] mem [128];
  logic [15:0] exp_mem [128];
  int pend, den_cnt, wr_cnt, done_cnt, rst_hi, ovl, lbusy, lcnt;
  int checks = 0, errors = 0;
  logic [6:0] paddr;
  logic pwe;
  logic [15:0] pdi;
  bit drdy_en = 1, lock_en = 1;
  clock_drp_reconfig #(.NUM_MODES(NM), .NUM_REGS(NR), .MODE_TABLE(TBL), .DRP_TIMEOUT(DT),
    .LOCK_TIMEOUT(LT), .RST_HOLD(HOLD)) dut (
    .clk_in(clk), .reset(reset), .start(start), .mode_sel(mode_sel), .busy(busy), .done(done),
    .error(error), .err_code(err_code), .mmcm_rst(mmcm_rst), .mmcm_locked(mmcm_locked),
    .locked_out(locked_out), .drp_daddr(drp_daddr), .drp_di(drp_di), .drp_den(drp_den),
    .drp_dwe(drp_dwe), .drp_do(drp_do), .drp_drdy(drp_drdy));
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  // DRP slave answering D cycles after den, MMCM locking LOCK_DLY cycles after its reset falls
  always @(negedge clk) begin
    drp_drdy = 0;
    if (reset) pend = 0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        if (pwe) mem[paddr] = pdi;
        else drp_do = mem[paddr];
        drp_drdy = 1;
      end
    end
    if (drp_den) begin
      den_cnt++;
      if (drp_dwe) wr_cnt++;
      if (pend > 0) ovl++;
      if (drdy_en) begin
        pend = D;
        paddr = drp_daddr;
        pwe = drp_dwe;
        pdi = drp_di;
      end
    end
    lcnt = mmcm_rst ? 0 : (lcnt < LOCK_DLY ? lcnt + 1 : lcnt);
    mmcm_locked = lock_en && lcnt >= LOCK_DLY;
    if (done) done_cnt++;
    if (mmcm_rst) rst_hi++;
    if (locked_out && busy) lbusy++;
  end
  function automatic logic [38:0] entry(input int m, input int k);
    return tbl_v[39*(m*NR+k) +: 39];
  endfunction
  task automatic calc_exp(input int m);
    logic [38:0] e;
    for (int i = 0; i < 128; i++) exp_mem[i] = mem[i];
    for (int k = 0; k < NR; k++) begin
      e = entry(m, k);
      exp_mem[e[38:32]] = (exp_mem[e[38:32]] & e[31:16]) | e[15:0];
    end
  endtask
  task automatic clr();
    den_cnt = 0;
    wr_cnt = 0;
    done_cnt = 0;
    rst_hi = 0;
  endtask
  task automatic pulse(input logic [1:0] m);
    @(negedge clk);
    #1 start = 1;
    mode_sel = m;
    @(negedge clk);
    #1 start = 0;
  endtask
  task automatic wait_idle(input int budget, output bit to);
    to = 1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        to = 0;
        break;
      end
    end
    repeat (2) @(negedge clk);
    #1;
  endtask
  task automatic run(input int m, output bit to);
    clr();
    pulse(2'(m));
    wait_idle(3000, to);
  endtask
  task automatic test_reset();
    reset = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, error, err_code, mmcm_rst, locked_out, drp_den, drp_dwe, drp_daddr, drp_di} !== 32'h0) begin
      errors++;
      $display("FAIL reset_values got busy=%b done=%b err=%b code=%b rst=%b lo=%b den=%b dwe=%b addr=%h di=%h required all 0",
        busy, done, error, err_code, mmcm_rst, locked_out, drp_den, drp_dwe, drp_daddr, drp_di);
    end
    reset = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, mmcm_rst, drp_den, error} !== 4'b0) begin
      errors++;
      $display("FAIL post_reset_idle got busy=%b rst=%b den=%b err=%b required 0", busy, mmcm_rst, drp_den, error);
    end
  endtask
  task automatic test_mode(input int m);
    bit to;
    logic [38:0] e;
    calc_exp(m);
    run(m, to);
    checks++;
    if (to) begin errors++; $display("FAIL mode%0d_timeout busy=%b required 0", m, busy); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL mode%0d_done_pulses got %0d required 1", m, done_cnt); end
    checks++;
    if (den_cnt !== 2*NR) begin errors++; $display("FAIL mode%0d_den_pulses got %0d required %0d", m, den_cnt, 2*NR); end
    checks++;
    if (rst_hi !== 1 + NR*(2+2*D) + HOLD) begin
      errors++; $display("FAIL mode%0d_rst_high got %0d required %0d", m, rst_hi, 1 + NR*(2+2*D) + HOLD);
    end
    checks++;
    if ({busy, error, err_code} !== 4'b0) begin
      errors++; $display("FAIL mode%0d_status got busy=%b err=%b code=%b required 0", m, busy, error, err_code);
    end
    checks++;
    if (locked_out !== 1) begin errors++; $display("FAIL mode%0d_locked_out got %b required 1", m, locked_out); end
    for (int k = 0; k < NR; k++) begin
      e = entry(m, k);
      checks++;
      if (mem[e[38:32]] !== exp_mem[e[38:32]]) begin
        errors++;
        $display("FAIL mode%0d_reg%0d addr=%h got %h required %h", m, k, e[38:32], mem[e[38:32]], exp_mem[e[38:32]]);
      end
    end
  endtask
  task automatic test_rmw();
    bit to;
    mem[7'h08] = 16'hABCD;
    run(0, to);
    checks++;
    if (mem[7'h08] !== 16'hAB12 || to) begin
      errors++; $display("FAIL rmw_example got %h timeout=%b required AB12", mem[7'h08], to);
    end
  endtask
  task automatic test_drdy_timeout();
    bit to;
    drdy_en = 0;
    run($urandom_range(0, NM-1), to);
    drdy_en = 1;
    checks++;
    if (to || error !== 1 || err_code !== 2'b01 || mmcm_rst !== 0 || busy !== 0) begin
      errors++;
      $display("FAIL drdy_timeout got to=%b err=%b code=%b rst=%b busy=%b required 0 1 01 0 0", to, error, err_code, mmcm_rst, busy);
    end
    checks++;
    if (done_cnt !== 0 || den_cnt !== 1) begin
      errors++; $display("FAIL drdy_timeout_counts got done=%0d den=%0d required 0 1", done_cnt, den_cnt);
    end
    checks++;
    if (rst_hi !== 2 + DT) begin errors++; $display("FAIL drdy_timeout_len got %0d required %0d", rst_hi, 2 + DT); end
  endtask
  task automatic test_lock_timeout();
    bit to;
    int m;
    m = $urandom_range(0, NM-1);
    lock_en = 0;
    run(m, to);
    checks++;
    if (to || error !== 1 || err_code !== 2'b10 || done_cnt !== 0 || locked_out !== 0) begin
      errors++;
      $display("FAIL lock_timeout got to=%b err=%b code=%b done=%0d lo=%b required 0 1 10 0 0", to, error, err_code, done_cnt, locked_out);
    end
    lock_en = 1;
    calc_exp(m);
    clr();
    pulse(2'(m));
    checks++;
    if (error !== 0 || err_code !== 2'b00 || busy !== 1) begin
      errors++; $display("FAIL lock_retry_clear got err=%b code=%b busy=%b required 0 00 1", error, err_code, busy);
    end
    wait_idle(3000, to);
    checks++;
    if (to || done_cnt !== 1 || error !== 0) begin
      errors++; $display("FAIL lock_retry_done got to=%b done=%0d err=%b required 0 1 0", to, done_cnt, error);
    end
  endtask
  task automatic test_illegal();
    clr();
    pulse(2'd3);
    checks++;
    if (error !== 1 || err_code !== 2'b11 || busy !== 0) begin
      errors++; $display("FAIL illegal_mode got err=%b code=%b busy=%b required 1 11 0", error, err_code, busy);
    end
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (den_cnt !== 0 || mmcm_rst !== 0) begin
      errors++; $display("FAIL illegal_no_drp got den=%0d rst=%b required 0 0", den_cnt, mmcm_rst);
    end
  endtask
  task automatic test_back_to_back();
    bit to;
    int m1, m2;
    logic [38:0] e;
    m1 = $urandom_range(0, NM-1);
    m2 = (m1 + 1) % NM;
    calc_exp(m1);
    clr();
    pulse(2'(m1));
    repeat ($urandom_range(2, 20)) @(negedge clk);
    pulse(2'(m2));
    wait_idle(3000, to);
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (to || done_cnt !== 1 || den_cnt !== 2*NR || busy !== 0) begin
      errors++; $display("FAIL busy_ignore got to=%b done=%0d den=%0d busy=%b required 0 1 %0d 0", to, done_cnt, den_cnt, busy, 2*NR);
    end
    for (int k = 0; k < NR; k++) begin
      e = entry(m1, k);
      checks++;
      if (mem[e[38:32]] !== exp_mem[e[38:32]]) begin
        errors++; $display("FAIL busy_ignore_reg%0d got %h required %h", k, mem[e[38:32]], exp_mem[e[38:32]]);
      end
    end
  endtask
  task automatic test_reset_mid();
    bit hit;
    hit = 0;
    clr();
    pulse(2'($urandom_range(0, NM-1)));
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      #1;
      if (wr_cnt >= 3) begin
        hit = 1;
        break;
      end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL reset_mid_third_write got %0d writes required 3", wr_cnt); end
    @(negedge clk);
    #2 reset = 1;
    #1;
    checks++;
    if ({busy, done, error, err_code, mmcm_rst, locked_out, drp_den, drp_dwe, drp_daddr, drp_di} !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_values got busy=%b rst=%b den=%b dwe=%b addr=%h di=%h required all 0",
        busy, mmcm_rst, drp_den, drp_dwe, drp_daddr, drp_di);
    end
    @(negedge clk);
    reset = 0;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_protocol();
    checks++;
    if (ovl !== 0) begin errors++; $display("FAIL drp_outstanding got %0d overlaps required 0", ovl); end
    checks++;
    if (lbusy !== 0) begin errors++; $display("FAIL locked_out_while_busy got %0d cycles required 0", lbusy); end
  endtask
  initial begin
    start = 0;
    mode_sel = 0;
    reset = 1;
    for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
    test_reset();
    test_mode(0);
    test_rmw();
    test_mode(1);
    test_mode(2);
    test_drdy_timeout();
    test_lock_timeout();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_mode($urandom_range(0, NM-1));
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
